// File: rtl/relay_ssp_framer_if.sv
// Relay-to-SSP framer bus: relay bit stream in, SSP serial stream and FIFO status out.
// master = stimulus/relay side, slave = framer.
interface relay_ssp_framer_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          bit_strobe;
  logic          bit_in;
  logic [2:0]    mod_type;
  logic          capture_en;
  logic          ssp_clk;
  logic          ssp_frame;
  logic          ssp_din;
  logic          overflow;
  logic [LW-1:0] fifo_level;

  modport master (
    output bit_strobe, bit_in, mod_type, capture_en, ssp_clk,
    input  ssp_frame, ssp_din, overflow, fifo_level
  );

  modport slave (
    input  bit_strobe, bit_in, mod_type, capture_en, ssp_clk,
    output ssp_frame, ssp_din, overflow, fifo_level
  );
endinterface

// File: rtl/relay_ssp_framer.sv
// relay_ssp_framer: packs relay bits MSB-first into bytes, queues them in a
// byte FIFO and shifts them out to the ARM over SSP (ssp_clk is asynchronous).
// Optional feature: define RELAY_SSP_MODTAG_EN to queue a marker byte
// {5'b11100, mod_type} whenever the relay mode code changes.
// FIFO_DEPTH must be a power of two >= 2 (pointers wrap by overflow).
module relay_ssp_framer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  relay_ssp_framer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} tx_state_t;
  tx_state_t state, state_nxt;

  logic          sync1, sync2, sync2_q, ssp_rise;
  logic [7:0]    pack_sr;
  logic [2:0]    bit_cnt;
  logic          data_push;
  logic [7:0]    data_byte;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          ovf;
  logic          push, pop, push_ok;
  logic [7:0]    push_byte;
  logic [7:0]    shifter;
  logic [2:0]    idx;
  logic          frame_pend;

  // Two-flop synchronizer on ssp_clk plus a delayed copy for rising-edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1   <= bus.ssp_clk;
      sync2   <= sync1;
      sync2_q <= sync2;
    end
  end
  assign ssp_rise = sync2 & ~sync2_q;

  // Packer: the byte completes on the strobe that carries the 8th bit
  assign data_push = bus.bit_strobe & bus.capture_en & (bit_cnt == 3'd7);
  assign data_byte = {pack_sr[6:0], bus.bit_in};

  // Shift relay bits in; dropping capture_en discards any partial byte
  always_ff @(posedge clk) begin
    if (reset || !bus.capture_en) begin
      pack_sr <= 8'h00;
      bit_cnt <= 3'd0;
    end else if (bus.bit_strobe) begin
      pack_sr <= data_byte;
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

`ifdef RELAY_SSP_MODTAG_EN
  logic [2:0] mod_q, tag_mod;
  logic       tag_pend, tag_push;

  // A data byte wins the FIFO write port; the marker waits one more cycle
  assign tag_push = tag_pend & ~data_push;

  // Track mode changes; reset re-arms on the current mode so it does not tag itself
  always_ff @(posedge clk) begin
    if (reset) begin
      mod_q    <= bus.mod_type;
      tag_mod  <= 3'd0;
      tag_pend <= 1'b0;
    end else begin
      mod_q <= bus.mod_type;
      if (bus.mod_type != mod_q) begin
        tag_pend <= 1'b1;
        tag_mod  <= bus.mod_type;
      end else if (tag_push) begin
        tag_pend <= 1'b0;
      end
    end
  end

  assign push      = data_push | tag_push;
  assign push_byte = data_push ? data_byte : {5'b11100, tag_mod};
`else
  logic mod_unused;
  assign mod_unused = ^bus.mod_type;
  assign push       = data_push;
  assign push_byte  = data_byte;
`endif

  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push_ok = push & ((level != FULL_LVL) | pop);

  // FIFO storage, no reset so it maps to distributed RAM
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_byte;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push && !push_ok) ovf <= 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Transmitter state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Transmitter next state; LOAD is only reachable with a non-empty FIFO
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:    if (level != '0) state_nxt = LOAD;
      LOAD: begin
        pop       = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT:   if (ssp_rise && idx == 3'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shifter, bit index and frame marker; edges outside SHIFT are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      shifter    <= 8'h00;
      idx        <= 3'd0;
      frame_pend <= 1'b0;
    end else if (state == LOAD) begin
      shifter    <= mem[rd_ptr];
      idx        <= 3'd7;
      frame_pend <= 1'b1;
    end else if (state == SHIFT && ssp_rise) begin
      idx        <= idx - 3'd1;
      frame_pend <= 1'b0;
    end
  end

  assign bus.ssp_din    = (state == SHIFT) & shifter[idx];
  assign bus.ssp_frame  = (state == SHIFT) & frame_pend;
  assign bus.overflow   = ovf;
  assign bus.fifo_level = level;
endmodule

// File: tb/tb_relay_ssp_framer.sv
// Directed bench for relay_ssp_framer: bytes are pushed to a scoreboard as
// they are strobed in and popped when the SSP side shifts them out.
`timescale 1ns/1ps
module tb_relay_ssp_framer;
  localparam int FIFO_DEPTH = 8;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] sb[$];
  logic [7:0] ovf_bytes [10] = '{8'h81, 8'h42, 8'h3C, 8'h99, 8'hA5,
                                 8'h5A, 8'h0F, 8'hF0, 8'hE7, 8'h7E};

  relay_ssp_framer_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();
  relay_ssp_framer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic strobe_bit(input logic b);
    bus.bit_strobe = 1'b1;
    bus.bit_in     = b;
    @(negedge clk);
    bus.bit_strobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_out);
    for (int i = 7; i >= 0; i--) strobe_bit(b[i]);
    if (expect_out) sb.push_back(b);
  endtask

  task automatic ssp_pulse();
    bus.ssp_clk = 1'b1;
    repeat (4) @(negedge clk);
    bus.ssp_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_frame(input string tag);
    for (int n = 0; n < 200; n++) begin
      if (bus.ssp_frame) break;
      @(negedge clk);
    end
    check({tag, "_frame_start"}, 32'(bus.ssp_frame), 32'd1);
  endtask

  task automatic rx_byte(input string tag);
    logic [7:0] d;
    logic [7:0] exp;
    wait_frame(tag);
    for (int i = 7; i >= 0; i--) begin
      d[i] = bus.ssp_din;
      if (i < 7) check({tag, "_frame_low"}, 32'(bus.ssp_frame), 32'd0);
      ssp_pulse();
    end
    exp = 'x;
    if (sb.size() > 0) exp = sb.pop_front();
    check({tag, "_byte"}, 32'(d), 32'(exp));
  endtask

  task automatic idle_check(input string tag);
    repeat (20) @(negedge clk);
    check({tag, "_frame"}, 32'(bus.ssp_frame), 32'd0);
    check({tag, "_din"}, 32'(bus.ssp_din), 32'd0);
    check({tag, "_level"}, 32'(bus.fifo_level), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    bus.bit_strobe = 1'b0;
    bus.bit_in     = 1'b0;
    bus.mod_type   = 3'd3;
    bus.capture_en = 1'b0;
    bus.ssp_clk    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_din", 32'(bus.ssp_din), 32'd0);
    check("rst_frame", 32'(bus.ssp_frame), 32'd0);
    check("rst_level", 32'(bus.fifo_level), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Capture 0xC0: level stays 0 until the 8th bit, then reads 1
    bus.capture_en = 1'b1;
    b = 8'hC0;
    for (int i = 7; i >= 1; i--) strobe_bit(b[i]);
    check("cap_level_pre", 32'(bus.fifo_level), 32'd0);
    strobe_bit(b[0]);
    check("cap_level_post", 32'(bus.fifo_level), 32'd1);
    sb.push_back(b);

    // Shift 0xC0 out over SSP, then the transmitter must sit idle
    rx_byte("ssp_c0");
    idle_check("ssp_idle");

    // Abort: 5 bits, capture dropped, then a full 0xFF
    strobe_bit(1'b1); strobe_bit(1'b0); strobe_bit(1'b1); strobe_bit(1'b1); strobe_bit(1'b0);
    bus.capture_en = 1'b0;
    @(negedge clk);
    bus.capture_en = 1'b1;
    send_byte(8'hFF, 1'b1);
    rx_byte("abort_ff");
    idle_check("abort_idle");

    // Mode change coincident with a byte completion
    b = 8'h5A;
    for (int i = 7; i >= 1; i--) strobe_bit(b[i]);
    bus.mod_type = 3'd4;
    strobe_bit(b[0]);
    sb.push_back(b);
`ifdef RELAY_SSP_MODTAG_EN
    sb.push_back(8'hE4);
    rx_byte("mark_data");
    rx_byte("mark_tag");
`else
    rx_byte("mark_data");
`endif
    idle_check("mark_idle");

    // Overflow: the first byte moves straight into the shifter (no ssp_clk),
    // the next 8 fill the FIFO and the 10th is dropped.
    for (int i = 0; i < 9; i++) send_byte(ovf_bytes[i], 1'b1);
    check("ovf_level_full", 32'(bus.fifo_level), 32'd8);
    check("ovf_flag_pre", 32'(bus.overflow), 32'd0);
    send_byte(ovf_bytes[9], 1'b0);
    check("ovf_level_hold", 32'(bus.fifo_level), 32'd8);
    check("ovf_flag_post", 32'(bus.overflow), 32'd1);
    rx_byte("ovf_b0");
    rx_byte("ovf_b1");
    check("ovf_flag_sticky", 32'(bus.overflow), 32'd1);

    // Reset at bit index 3 of 0x3C (bit 3 is a one)
    wait_frame("rst_mid");
    repeat (4) ssp_pulse();
    check("rst_mid_bit3", 32'(bus.ssp_din), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_din", 32'(bus.ssp_din), 32'd0);
    check("rst_mid_frame", 32'(bus.ssp_frame), 32'd0);
    check("rst_mid_level", 32'(bus.fifo_level), 32'd0);
    check("rst_mid_ovf", 32'(bus.overflow), 32'd0);
    reset = 1'b0;
    sb.delete();
    idle_check("rst_mid_idle");

    // Reset mid-pack: the 3 partial bits must not leak into the next byte
    strobe_bit(1'b1); strobe_bit(1'b1); strobe_bit(1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_byte(8'hA5, 1'b1);
    rx_byte("rst_pack_a5");
    idle_check("end_idle");
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
